// File: rtl/opb_regbank_pkg.sv
// -----------------------------------------------------------------------------
// opb_regbank_pkg
//   Shared constants and helpers for the OPB register bank.
//   - REG_STRIDE  : byte distance between consecutive registers.
//   - CTRL_OFFSET : window offset of the commit/status register. It only
//                   exists when OPB_REGBANK_SHADOW_EN is defined.
//   - COMMIT_BIT  : bit of the control word that requests a commit.
//   - opb_to_user32 / opb_to_user_be : convert OPB big-endian bit numbering
//                   (bit 0 = MSB) to user little-endian numbering (bit 31 = MSB).
// -----------------------------------------------------------------------------
package opb_regbank_pkg;

   localparam int unsigned REG_STRIDE  = 4;
   localparam logic [7:0]  CTRL_OFFSET = 8'h80;
   localparam int unsigned COMMIT_BIT  = 0;

   // OPB bit k is the k-th bit counted from the MSB, which is user bit 31-k.
   function automatic logic [31:0] opb_to_user32(input logic [0:31] v);
      logic [31:0] r;
      for (int k = 0; k < 32; k++) begin
         r[31-k] = v[k];
      end
      return r;
   endfunction

   // BE[0] covers the MSB byte, so it becomes user byte-enable bit 3.
   function automatic logic [3:0] opb_to_user_be(input logic [0:3] be);
      logic [3:0] r;
      for (int k = 0; k < 4; k++) begin
         r[3-k] = be[k];
      end
      return r;
   endfunction

   // Replace the enabled bytes of old_v with the matching bytes of new_v.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/opb_slave_decode.sv
// -----------------------------------------------------------------------------
// opb_slave_decode
//   Generic OPB slave front end: address-window hit detection, window offset,
//   and the registered transfer acknowledge with its mandatory one-cycle gap.
//
//   Ports:
//     clk_i     : OPB clock
//     rst_i     : synchronous active-high reset; drops any pending ack
//     select_i  : OPB_select
//     addr_i    : OPB address, user bit order
//     hit_o     : this cycle is a new transfer for this slave
//     offset_o  : addr_i - C_BASEADDR
//     ack_o     : registered acknowledge, high exactly one cycle after a hit
//
//   Handshake: a hit is select_i & in-window & ~ack_o. The ack rises in the
//   cycle after the hit and, because a hit is masked while the ack is high,
//   two acks are always separated by at least one idle cycle even if the
//   master keeps select_i asserted.
// -----------------------------------------------------------------------------
module opb_slave_decode #(
   parameter int                  C_AWIDTH   = 32,
   parameter logic [C_AWIDTH-1:0] C_BASEADDR = '0,
   parameter logic [C_AWIDTH-1:0] C_HIGHADDR = C_AWIDTH'(32'h0000_00FF)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                select_i,
   input  logic [C_AWIDTH-1:0] addr_i,
   output logic                hit_o,
   output logic [C_AWIDTH-1:0] offset_o,
   output logic                ack_o
);

   logic in_window;
   logic ack_q;
   logic ack_d;

   always_comb begin
      in_window = (addr_i >= C_BASEADDR) && (addr_i <= C_HIGHADDR);
      hit_o     = select_i && in_window && !ack_q;
      offset_o  = addr_i - C_BASEADDR;
      ack_d     = hit_o;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_q <= 1'b0;
      end else begin
         ack_q <= ack_d;
      end
   end

   assign ack_o = ack_q;

endmodule

// File: rtl/opb_register_bank.sv
// -----------------------------------------------------------------------------
// opb_register_bank
//   Bank of C_NUM_REGS software-writable 32-bit control registers on the OPB.
//   Each register drives a fabric-side word and a one-cycle update strobe.
//
//   Build option OPB_REGBANK_SHADOW_EN:
//     defined   - writes land in shadow registers and set a dirty bit; a write
//                 of COMMIT=1 to offset 0x80 copies every shadow to live on one
//                 edge and pulses user_update for the dirty registers. Reading
//                 0x80 returns the dirty mask.
//     undefined - writes go straight to the live registers; 0x80 is unmapped.
//
//   Ports:
//     OPB_Clk, OPB_Rst       : clock, synchronous active-high reset
//     OPB_ABus, OPB_BE,
//     OPB_DBus, OPB_RNW,
//     OPB_select, OPB_seqAddr: OPB master request (seqAddr is ignored)
//     Sl_DBus, Sl_xferAck    : registered read data / acknowledge
//     Sl_errAck, Sl_retry,
//     Sl_toutSup             : tied low
//     user_data_out          : live registers, register i at [32i+31:32i]
//     user_update            : one-cycle pulse when live register i loads
//
//   Every output comes from a flop, so there is no combinational path from
//   the OPB inputs to any output.
// -----------------------------------------------------------------------------
module opb_register_bank
   import opb_regbank_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
   parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter int          C_NUM_REGS   = 4,
   parameter logic [31:0] C_RESET_VAL  = 32'h0000_0000
) (
   input  logic                         OPB_Clk,
   input  logic                         OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]      OPB_ABus,
   input  logic [0:3]                   OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]      OPB_DBus,
   input  logic                         OPB_RNW,
   input  logic                         OPB_select,
   input  logic                         OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]      Sl_DBus,
   output logic                         Sl_xferAck,
   output logic                         Sl_errAck,
   output logic                         Sl_retry,
   output logic                         Sl_toutSup,
   output logic [32*C_NUM_REGS-1:0]     user_data_out,
   output logic [C_NUM_REGS-1:0]        user_update
);

   // ---------------------------------------------------------------- decode
   logic [C_OPB_AWIDTH-1:0] addr_user;
   logic [C_OPB_AWIDTH-1:0] offset;
   logic [C_OPB_AWIDTH-1:0] offset_w;
   logic                    hit;
   logic                    ack;

   // Positional assignment keeps the numeric value: OPB bit 0 lands on the MSB.
   assign addr_user = OPB_ABus;

   opb_slave_decode #(
      .C_AWIDTH   (C_OPB_AWIDTH),
      .C_BASEADDR (C_OPB_AWIDTH'(C_BASEADDR)),
      .C_HIGHADDR (C_OPB_AWIDTH'(C_HIGHADDR))
   ) u_decode (
      .clk_i    (OPB_Clk),
      .rst_i    (OPB_Rst),
      .select_i (OPB_select),
      .addr_i   (addr_user),
      .hit_o    (hit),
      .offset_o (offset),
      .ack_o    (ack)
   );

   logic [31:0] wr_user;
   logic [3:0]  be_user;
   logic        reg_sel;
   logic [3:0]  idx;

   always_comb begin
      // Byte lanes within a word are ignored: accesses are word aligned.
      offset_w = {offset[C_OPB_AWIDTH-1:2], 2'b00};
      wr_user  = opb_to_user32(OPB_DBus);
      be_user  = opb_to_user_be(OPB_BE);
      reg_sel  = offset_w < C_OPB_AWIDTH'(REG_STRIDE * C_NUM_REGS);
      idx      = offset_w[5:2];
   end

   // ---------------------------------------------------------------- state
   logic [C_NUM_REGS-1:0][31:0] live_q, live_d;
   logic [C_NUM_REGS-1:0]       upd_q, upd_d;
   logic [31:0]                 rdata_q, rdata_d;
   logic [31:0]                 rd_word;

`ifdef OPB_REGBANK_SHADOW_EN
   logic [C_NUM_REGS-1:0][31:0] shadow_q, shadow_d;
   logic [C_NUM_REGS-1:0]       dirty_q, dirty_d;
   logic                        ctrl_sel;

   assign ctrl_sel = offset_w == C_OPB_AWIDTH'(CTRL_OFFSET);
`endif

   // Read mux: reads see the value software last wrote (shadow when present).
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
         if (reg_sel && (idx == 4'(i))) begin
`ifdef OPB_REGBANK_SHADOW_EN
            rd_word = shadow_q[i];
`else
            rd_word = live_q[i];
`endif
         end
      end
`ifdef OPB_REGBANK_SHADOW_EN
      if (ctrl_sel) begin
         rd_word = 32'(dirty_q);
      end
`endif
   end

   always_comb begin
      live_d  = live_q;
      upd_d   = '0;
      rdata_d = '0;
`ifdef OPB_REGBANK_SHADOW_EN
      shadow_d = shadow_q;
      dirty_d  = dirty_q;
`endif
      if (hit) begin
         if (OPB_RNW) begin
            rdata_d = rd_word;
         end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
               if (reg_sel && (idx == 4'(i))) begin
`ifdef OPB_REGBANK_SHADOW_EN
                  shadow_d[i] = merge_bytes(shadow_q[i], wr_user, be_user);
                  dirty_d[i]  = 1'b1;
`else
                  live_d[i]   = merge_bytes(live_q[i], wr_user, be_user);
                  upd_d[i]    = 1'b1;
`endif
               end
            end
`ifdef OPB_REGBANK_SHADOW_EN
            // COMMIT lives in the least significant byte, so that byte lane
            // must be enabled for the request to count. Clean registers
            // already hold shadow == live, so copying all of them is safe.
            if (ctrl_sel && be_user[0] && wr_user[COMMIT_BIT]) begin
               live_d  = shadow_q;
               upd_d   = dirty_q;
               dirty_d = '0;
            end
`endif
         end
      end
   end

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         live_q  <= {C_NUM_REGS{C_RESET_VAL}};
         upd_q   <= '0;
         rdata_q <= '0;
`ifdef OPB_REGBANK_SHADOW_EN
         shadow_q <= {C_NUM_REGS{C_RESET_VAL}};
         dirty_q  <= '0;
`endif
      end else begin
         live_q  <= live_d;
         upd_q   <= upd_d;
         rdata_q <= rdata_d;
`ifdef OPB_REGBANK_SHADOW_EN
         shadow_q <= shadow_d;
         dirty_q  <= dirty_d;
`endif
      end
   end

   // ---------------------------------------------------------------- outputs
   // rdata_q is non-zero only in the cycle after a read hit, i.e. the ack cycle.
   assign Sl_DBus       = rdata_q;
   assign Sl_xferAck    = ack;
   assign Sl_errAck     = 1'b0;
   assign Sl_retry      = 1'b0;
   assign Sl_toutSup    = 1'b0;
   assign user_data_out = live_q;
   assign user_update   = upd_q;

   logic unused_inputs;
   assign unused_inputs = ^{OPB_seqAddr, offset[1:0]};

endmodule

// File: tb/tb_opb_register_bank.sv
module tb_opb_register_bank;

   localparam logic [31:0] RV   = 32'hA5A5_0F0F;
   localparam int          NREG = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [0:31]  abus;
   logic [0:3]   be;
   logic [0:31]  dbus;
   logic         rnw;
   logic         sel;
   logic         seq_addr;
   logic [0:31]  sl_dbus;
   logic         sl_ack;
   logic         sl_err;
   logic         sl_retry;
   logic         sl_tout;
   logic [32*NREG-1:0] user_data;
   logic [NREG-1:0]    user_upd;

   int vectors     = 0;
   int miscompares = 0;

   // results of the most recent transfer
   int              last_lat;
   logic [31:0]     last_rdata;
   logic [NREG-1:0] last_upd;
   logic [127:0]    last_live;
   logic            last_ack_after;
   logic [NREG-1:0] last_upd_after;
   logic [31:0]     last_dbus_after;

   opb_register_bank #(
      .C_BASEADDR   (32'h0000_0000),
      .C_HIGHADDR   (32'h0000_00FF),
      .C_OPB_AWIDTH (32),
      .C_OPB_DWIDTH (32),
      .C_NUM_REGS   (NREG),
      .C_RESET_VAL  (RV)
   ) dut (
      .OPB_Clk       (clk),
      .OPB_Rst       (rst),
      .OPB_ABus      (abus),
      .OPB_BE        (be),
      .OPB_DBus      (dbus),
      .OPB_RNW       (rnw),
      .OPB_select    (sel),
      .OPB_seqAddr   (seq_addr),
      .Sl_DBus       (sl_dbus),
      .Sl_xferAck    (sl_ack),
      .Sl_errAck     (sl_err),
      .Sl_retry      (sl_retry),
      .Sl_toutSup    (sl_tout),
      .user_data_out (user_data),
      .user_update   (user_upd)
   );

   // ------------------------------------------------------------ clock
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ checker
   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------------ driver
   // One complete transfer: drive at the falling edge, sample 1 time unit
   // after each rising edge until the ack shows (bounded), then one idle
   // cycle so the next transfer starts clear of the ack gap.
   task automatic xfer(input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
      last_lat   = -1;
      last_rdata = '0;
      last_upd   = '0;
      last_live  = '0;
      @(negedge clk);
      sel  = 1'b1;
      rnw  = r;
      abus = a;
      dbus = r ? 32'h0 : d;
      be   = b;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk);
         #1;
         if (sl_ack) begin
            last_lat   = c;
            last_rdata = sl_dbus;
            last_upd   = user_upd;
            last_live  = user_data;
            break;
         end
      end
      sel  = 1'b0;
      rnw  = 1'b0;
      dbus = '0;
      be   = '0;
      @(posedge clk);
      #1;
      last_ack_after  = sl_ack;
      last_upd_after  = user_upd;
      last_dbus_after = sl_dbus;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b);
      xfer(1'b0, a, d, b);
   endtask

   task automatic rd(input logic [31:0] a);
      xfer(1'b1, a, 32'h0, 4'h0);
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      logic [5:0] ack_pat;
      int         ack_cnt;

      rst = 1'b1; sel = 1'b0; rnw = 1'b0; abus = '0; dbus = '0; be = '0;
      seq_addr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // reset state
      check("rst_ack",  128'(sl_ack), 128'(0));
      check("rst_dbus", 128'(sl_dbus), 128'(0));
      check("rst_upd",  128'(user_upd), 128'(0));
      check("rst_live", 128'(user_data), {RV, RV, RV, RV});
      check("rst_tied", 128'({sl_err, sl_retry, sl_tout}), 128'(0));

      // read reg 2 after reset
      rd(32'h8);
      check("rd2_lat",   128'(last_lat), 128'(1));
      check("rd2_data",  128'(last_rdata), 128'(RV));
      check("rd2_upd",   128'(last_upd), 128'(0));
      check("rd2_ack_after",  128'(last_ack_after), 128'(0));
      check("rd2_dbus_after", 128'(last_dbus_after), 128'(0));

      // select held for 6 cycles: acks at cycles 1, 3, 5
      @(negedge clk);
      sel = 1'b1; rnw = 1'b1; abus = 32'h0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         ack_pat[k] = sl_ack;
      end
      sel = 1'b0; rnw = 1'b0;
      @(posedge clk);
      #1;
      check("hold_ack_pattern", 128'(ack_pat), 128'(6'b010101));

      // out-of-window address is never acked
      @(negedge clk);
      sel = 1'b1; rnw = 1'b1; abus = 32'h104;
      ack_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (sl_ack) ack_cnt++;
      end
      sel = 1'b0; rnw = 1'b0; abus = '0;
      @(posedge clk);
      #1;
      check("oow_acks", 128'(ack_cnt), 128'(0));

`ifdef OPB_REGBANK_SHADOW_EN
      wr(32'h0, 32'h5, 4'hF);
      check("sh_w0_lat",  128'(last_lat), 128'(1));
      check("sh_w0_upd",  128'(last_upd), 128'(0));
      check("sh_w0_live", last_live, {RV, RV, RV, RV});
      wr(32'hC, 32'h9, 4'hF);
      check("sh_w3_upd",  128'(last_upd), 128'(0));
      check("sh_w3_live", last_live, {RV, RV, RV, RV});
      rd(32'h80);
      check("sh_dirty_1001", 128'(last_rdata), 128'(32'h9));
      rd(32'h0);
      check("sh_rd0_shadow", 128'(last_rdata), 128'(32'h5));
      wr(32'h80, 32'h1, 4'hF);
      check("sh_commit_lat",  128'(last_lat), 128'(1));
      check("sh_commit_upd",  128'(last_upd), 128'(4'b1001));
      check("sh_commit_live", last_live, {32'h9, RV, RV, 32'h5});
      check("sh_commit_upd_after", 128'(last_upd_after), 128'(0));
      rd(32'h80);
      check("sh_dirty_clear", 128'(last_rdata), 128'(0));
      wr(32'h80, 32'h1, 4'hF);
      check("sh_empty_commit_lat",  128'(last_lat), 128'(1));
      check("sh_empty_commit_upd",  128'(last_upd), 128'(0));
      check("sh_empty_commit_live", last_live, {32'h9, RV, RV, 32'h5});
      wr(32'h4, 32'h7, 4'hF);
      wr(32'h80, 32'h0, 4'hF);
      check("sh_commit0_upd",  128'(last_upd), 128'(0));
      check("sh_commit0_live", last_live, {32'h9, RV, RV, 32'h5});
      rd(32'h80);
      check("sh_dirty_0010", 128'(last_rdata), 128'(32'h2));
`else
      wr(32'h4, 32'h1122_3344, 4'hF);
      check("d_w1_lat",  128'(last_lat), 128'(1));
      check("d_w1_upd",  128'(last_upd), 128'(4'b0010));
      check("d_w1_live", last_live, {RV, RV, 32'h1122_3344, RV});
      wr(32'h4, 32'hDEAD_BEEF, 4'b0011);
      check("d_be_upd",  128'(last_upd), 128'(4'b0010));
      check("d_be_live", last_live, {RV, RV, 32'h1122_BEEF, RV});
      check("d_be_upd_after", 128'(last_upd_after), 128'(0));
      rd(32'h4);
      check("d_rd1", 128'(last_rdata), 128'(32'h1122_BEEF));
      wr(32'hC, 32'hCAFE_F00D, 4'b1000);
      check("d_w3_upd",  128'(last_upd), 128'(4'b1000));
      check("d_w3_live", last_live, {32'hCAA5_0F0F, RV, 32'h1122_BEEF, RV});
      wr(32'h80, 32'h1, 4'hF);
      check("d_ctrl_lat",  128'(last_lat), 128'(1));
      check("d_ctrl_upd",  128'(last_upd), 128'(0));
      check("d_ctrl_live", last_live, {32'hCAA5_0F0F, RV, 32'h1122_BEEF, RV});
      rd(32'h80);
      check("d_ctrl_rd", 128'(last_rdata), 128'(0));
`endif

      // unmapped in-window offset: acked, reads zero
      rd(32'h40);
      check("unmapped_lat",  128'(last_lat), 128'(1));
      check("unmapped_data", 128'(last_rdata), 128'(0));

      // reset asserted in the hit cycle of a write
      @(negedge clk);
      rst = 1'b1; sel = 1'b1; rnw = 1'b0; abus = 32'h0; dbus = 32'h1234_5678;
      be = 4'hF;
      @(posedge clk);
      #1;
      rst = 1'b0; sel = 1'b0; dbus = '0; be = '0;
      check("rstw_ack0", 128'(sl_ack), 128'(0));
      check("rstw_upd0", 128'(user_upd), 128'(0));
      @(posedge clk);
      #1;
      check("rstw_ack1", 128'(sl_ack), 128'(0));
      check("rstw_upd1", 128'(user_upd), 128'(0));
      check("rstw_live", 128'(user_data), {RV, RV, RV, RV});
      rd(32'h0);
      check("rstw_rd0", 128'(last_rdata), 128'(RV));
      rd(32'h4);
      check("rstw_rd1", 128'(last_rdata), 128'(RV));
      rd(32'hC);
      check("rstw_rd3", 128'(last_rdata), 128'(RV));

      $display("== %0d vectors applied, %0d miscompares ==", vectors,
               miscompares);
      $finish;
   end

endmodule
